// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encodings, MDU FSM states and iteration count.
package mips_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } mduState_t;

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath: one shift-add or restoring shift-subtract step per cycle,
// sign fixup on the result. Divide logic exists only when MIPS_MDU_DIV_EN is defined.
module mdu_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        isSigned,
`ifdef MIPS_MDU_DIV_EN
    input  logic        isDiv,
`endif
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] resHi,
    output logic [31:0] resLo
);

    logic [63:0] acc;
    logic [31:0] opnd;
    logic        negP;
    logic        signA;
    logic        signB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] addSum;
    logic [63:0] prod;

    assign signA  = isSigned & srcA[31];
    assign signB  = isSigned & srcB[31];
    assign magA   = signA ? -srcA : srcA;
    assign magB   = signB ? -srcB : srcB;
    assign addSum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign prod   = negP ? -acc : acc;

`ifdef MIPS_MDU_DIV_EN
    logic [32:0] rem;
    logic        isDivQ;
    logic        negR;
    logic [33:0] trial;
    logic [33:0] diff;
    logic        qBit;
    logic [31:0] quo;
    logic [31:0] remOut;
    logic        divZero;

    // Borrow out of the 34-bit trial subtraction means the divisor did not fit.
    assign trial   = {rem, acc[31]};
    assign diff    = trial - {2'b00, opnd};
    assign qBit    = ~diff[33];
    assign quo     = negP ? -acc[31:0] : acc[31:0];
    assign remOut  = negR ? -rem[31:0] : rem[31:0];
    assign divZero = (opnd == 32'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
            negP <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
            rem    <= '0;
            isDivQ <= 1'b0;
            negR   <= 1'b0;
`endif
        end else if (load) begin
            negP <= signA ^ signB;
`ifdef MIPS_MDU_DIV_EN
            rem    <= '0;
            isDivQ <= isDiv;
            negR   <= signA;
            if (isDiv) begin
                opnd <= magB;
                acc  <= {32'd0, magA};
            end else begin
                opnd <= magA;
                acc  <= {32'd0, magB};
            end
`else
            opnd <= magA;
            acc  <= {32'd0, magB};
`endif
        end else if (step) begin
`ifdef MIPS_MDU_DIV_EN
            if (isDivQ) begin
                rem       <= qBit ? diff[32:0] : trial[32:0];
                acc[31:0] <= {acc[30:0], qBit};
            end else begin
                acc <= {addSum, acc[31:1]};
            end
`else
            acc <= {addSum, acc[31:1]};
`endif
        end
    end

`ifdef MIPS_MDU_DIV_EN
    // Divide by zero leaves the dividend magnitude in rem, so HI recovers SrcAE after sign fixup.
    always_comb begin
        resHi = prod[63:32];
        resLo = prod[31:0];
        if (isDivQ) begin
            resHi = remOut;
            resLo = divZero ? 32'hFFFF_FFFF : quo;
        end
    end
`else
    assign resHi = prod[63:32];
    assign resLo = prod[31:0];
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide unit control: FSM, iteration counter, HI/LO and stall request.
// DIV/DIVU are supported only when MIPS_MDU_DIV_EN is defined; otherwise they are ignored.
//
// state   | meaning
// IDLE    | waiting for StartE; MTHI/MTLO accepted
// RUN     | one arithmetic step per cycle, counter 0..31
// FIN     | result written to HI/LO, MdDone pulses
module mdu_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StartE,
    input  logic [1:0]  OpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        MdUseD,
    input  logic        MtHiW,
    input  logic        MtLoW,
    input  logic [31:0] WDataW,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        MdStallD,
    output logic        MdDone
);

    mduState_t   state;
    mduState_t   nextState;
    logic [4:0]  cnt;
    logic        startOk;
    logic        load;
    logic        step;
    logic [31:0] resHi;
    logic [31:0] resLo;

`ifdef MIPS_MDU_DIV_EN
    assign startOk = StartE;
`else
    assign startOk = StartE & ~isDivOp(OpE);
`endif

    mdu_core uCore (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .isSigned (isSignedOp(OpE)),
`ifdef MIPS_MDU_DIV_EN
        .isDiv    (isDivOp(OpE)),
`endif
        .srcA     (SrcAE),
        .srcB     (SrcBE),
        .resHi    (resHi),
        .resLo    (resLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        load      = 1'b0;
        step      = 1'b0;
        MdDone    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (startOk) begin
                    load      = 1'b1;
                    nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == 5'(MDU_ITER - 1)) nextState = ST_FIN;
            end
            ST_FIN: begin
                MdDone    = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 5'd1;
        end
    end

    // The FIN write wins; MT writes are honoured only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HI <= '0;
            LO <= '0;
        end else if (state == ST_FIN) begin
            HI <= resHi;
            LO <= resLo;
        end else if (state == ST_IDLE) begin
            if (MtHiW) HI <= WDataW;
            if (MtLoW) LO <= WDataW;
        end
    end

    assign MdStallD = MdUseD & ((state != ST_IDLE) | startOk);

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n) !(StartE && state != ST_IDLE))
        else $error("mdu_ctrl: StartE while busy is ignored");
    assert property (@(posedge clk) disable iff (!rst_n) !((MtHiW || MtLoW) && state != ST_IDLE))
        else $error("mdu_ctrl: MTHI/MTLO while busy is lost");
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops push expected HI/LO; a monitor checks them at MdDone.
module tb_mdu_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  OpE = 2'b00;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        MdUseD = 1'b0;
    logic        MtHiW = 1'b0;
    logic        MtLoW = 1'b0;
    logic [31:0] WDataW = '0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        MdStallD;
    logic        MdDone;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          startCyc;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;

    mdu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .StartE   (StartE),
        .OpE      (OpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .MdUseD   (MdUseD),
        .MtHiW    (MtHiW),
        .MtLoW    (MtLoW),
        .WDataW   (WDataW),
        .HI       (HI),
        .LO       (LO),
        .MdStallD (MdStallD),
        .MdDone   (MdDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic startOp(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input bit expectDone);
        exp_t e;
        @(negedge clk);
        StartE = 1'b1;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        if (expectDone) begin
            e.hi = hi;
            e.lo = lo;
            e.startCyc = cyc;
            e.name = name;
            expQ.push_back(e);
        end
        @(negedge clk);
        StartE = 1'b0;
        SrcAE  = '0;
        SrcBE  = '0;
    endtask

    // Monitor: every MdDone must match the oldest outstanding op.
    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n && MdDone) begin
            if (expQ.size() == 0) begin
                check("unexpected MdDone", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                check({e.name, " done latency"}, 64'(cyc - e.startCyc), 64'd33);
                @(negedge clk);
                check({e.name, " done pulse width"}, {63'd0, MdDone}, 64'd0);
                check({e.name, " HI"}, {32'd0, HI}, {32'd0, e.hi});
                check({e.name, " LO"}, {32'd0, LO}, {32'd0, e.lo});
            end
        end
    end

    initial begin
        bit sawStall;
        bit sawDone;

        repeat (2) @(negedge clk);
        #1;
        check("reset HI", {32'd0, HI}, 64'd0);
        check("reset LO", {32'd0, LO}, 64'd0);
        check("reset MdDone", {63'd0, MdDone}, 64'd0);
        check("reset MdStallD", {63'd0, MdStallD}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -3*7 with a dependent instruction waiting in D.
        startOp("mult -3*7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            MdUseD = 1'b1;
            #1;
            check($sformatf("stall busy cycle %0d", k), {63'd0, MdStallD}, 64'd1);
            @(negedge clk);
        end
        #1;
        check("stall first idle", {63'd0, MdStallD}, 64'd0);
        MdUseD = 1'b0;
        repeat (2) @(negedge clk);

        startOp("multu max*max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            #1;
            if (k % 8 == 1) check($sformatf("no use no stall %0d", k), {63'd0, MdStallD}, 64'd0);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        startOp("mult min*min", MDU_MULT, 32'h8000_0000, 32'h8000_0000,
                32'h4000_0000, 32'h0000_0000, 1'b1);
        repeat (35) @(negedge clk);
        startOp("mult 5*-1", MDU_MULT, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        repeat (35) @(negedge clk);

        MtHiW = 1'b1;
        WDataW = 32'hDEAD_BEEF;
        @(negedge clk);
        MtHiW = 1'b0;
        MtLoW = 1'b1;
        WDataW = 32'hCAFE_F00D;
        #1;
        check("mthi HI", {32'd0, HI}, 64'hDEAD_BEEF);
        @(negedge clk);
        MtLoW = 1'b0;
        #1;
        check("mtlo LO", {32'd0, LO}, 64'hCAFE_F00D);
        check("mtlo keeps HI", {32'd0, HI}, 64'hDEAD_BEEF);

`ifdef MIPS_MDU_DIV_EN
        startOp("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        repeat (35) @(negedge clk);
        startOp("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        repeat (35) @(negedge clk);
        startOp("div 5/0", MDU_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        repeat (35) @(negedge clk);
        startOp("div -5/0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        repeat (35) @(negedge clk);
        startOp("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
        repeat (35) @(negedge clk);
        startOp("divu max/16", MDU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b1);
        repeat (35) @(negedge clk);
`else
        // Divide is compiled out: DIV must be a silent no-op.
        @(negedge clk);
        StartE = 1'b1;
        OpE    = MDU_DIV;
        SrcAE  = 32'd5;
        SrcBE  = 32'd2;
        MdUseD = 1'b1;
        #1;
        check("div disabled start stall", {63'd0, MdStallD}, 64'd0);
        @(negedge clk);
        StartE = 1'b0;
        sawStall = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 36; k++) begin
            #1;
            sawStall |= MdStallD;
            sawDone |= MdDone;
            @(negedge clk);
        end
        MdUseD = 1'b0;
        check("div disabled never stalls", {63'd0, sawStall}, 64'd0);
        check("div disabled never done", {63'd0, sawDone}, 64'd0);
        check("div disabled HI", {32'd0, HI}, 64'hDEAD_BEEF);
        check("div disabled LO", {32'd0, LO}, 64'hCAFE_F00D);
`endif

        // Reset during RUN cycle 10 abandons the op.
        startOp("multu abandoned", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset HI", {32'd0, HI}, 64'd0);
        check("midrun reset LO", {32'd0, LO}, 64'd0);
        check("midrun reset MdDone", {63'd0, MdDone}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        MdUseD = 1'b1;
        #1;
        check("after reset idle no stall", {63'd0, MdStallD}, 64'd0);
        MdUseD = 1'b0;
        MtLoW = 1'b1;
        WDataW = 32'h0000_1234;
        @(negedge clk);
        MtLoW = 1'b0;
        #1;
        check("after reset mtlo LO", {32'd0, LO}, 64'h1234);
        check("after reset HI", {32'd0, HI}, 64'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
